// File: rtl/key_pkg.sv
// Shared definitions for the key event classifier: FSM state encoding,
// default timing constants and a small sizing helper.
package key_pkg;

    // Classifier states; held is high in PRESSED, PRESSED2 and LONG_HELD.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        WAIT_2ND  = 3'd2,
        PRESSED2  = 3'd3,
        LONG_HELD = 3'd4
    } key_state_e;

    // Default thresholds, in clock cycles.
    localparam int LONG_CYC_DEF   = 1000;
    localparam int DCLICK_CYC_DEF = 300;
    localparam int REPEAT_CYC_DEF = 200;

    // Largest of three thresholds, used to size the shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Edge detector for one debounced key: registers the level and flags the
// rising and falling transitions combinationally against that register.
// Reusable for any active-high debounced key input.
module key_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic key_lvl,
    output logic rise,
    output logic fall
);

    logic key_q;

    // Previous-cycle key level; cleared by reset so a key held through reset
    // release is seen as a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key_lvl;
        end
    end

    assign rise = key_lvl & ~key_q;
    assign fall = ~key_lvl & key_q;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: turns a debounced key level into single-cycle event pulses
// (press, release, short click, double click, long press, auto-repeat).
//
// Optional feature macro: KEY_REPEAT_EN. When defined, a key held past the
// long-press threshold emits repeat_p every REPEAT_CYC cycles; when
// undefined, repeat_p is tied low and the counter idles in LONG_HELD.
//
// All outputs are registered. An edge always wins over a threshold reached
// in the same cycle. state_dbg exposes the current FSM state for checkers.
module key_event_gen
    import key_pkg::*;
#(
    parameter int LONG_CYC   = LONG_CYC_DEF,
    parameter int DCLICK_CYC = DCLICK_CYC_DEF,
    parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_lvl,
    output logic       press_p,
    output logic       release_p,
    output logic       short_p,
    output logic       double_p,
    output logic       long_p,
    output logic       repeat_p,
    output logic       held,
    output key_state_e state_dbg
);

    // One counter serves every threshold; each threshold forces a state exit
    // or a reload, so it never needs to wrap.
    localparam int CNT_W = $clog2(max3(LONG_CYC, DCLICK_CYC, REPEAT_CYC)) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
`endif

    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fall;
    logic             repeat_q;

    key_edge_det u_edge (
        .clk     (clk),
        .rst     (rst),
        .key_lvl (key_lvl),
        .rise    (rise),
        .fall    (fall)
    );

    // Classifier FSM with shared counter and registered event outputs.
    // Pulse outputs default to 0 each cycle so every pulse lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            short_p   <= 1'b0;
            double_p  <= 1'b0;
            long_p    <= 1'b0;
            repeat_q  <= 1'b0;
            held      <= 1'b0;
        end else begin
            press_p   <= 1'b0;
            release_p <= 1'b0;
            short_p   <= 1'b0;
            double_p  <= 1'b0;
            long_p    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        press_p <= 1'b1;
                        held    <= 1'b1;
                        cnt     <= '0;
                        state   <= PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        release_p <= 1'b1;
                        held      <= 1'b0;
                        cnt       <= '0;
                        state     <= WAIT_2ND;
                    end else if (cnt == LONG_LAST) begin
                        long_p <= 1'b1;
                        cnt    <= '0;
                        state  <= LONG_HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_2ND: begin
                    if (rise) begin
                        press_p <= 1'b1;
                        held    <= 1'b1;
                        cnt     <= '0;
                        state   <= PRESSED2;
                    end else if (cnt == DCLICK_LAST) begin
                        short_p <= 1'b1;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED2: begin
                    if (fall) begin
                        release_p <= 1'b1;
                        double_p  <= 1'b1;
                        held      <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else if (cnt == LONG_LAST) begin
                        long_p <= 1'b1;
                        cnt    <= '0;
                        state  <= LONG_HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        release_p <= 1'b1;
                        held      <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    held  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    assign repeat_p = repeat_q;
`else
    assign repeat_p = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_key_event_gen.sv
// Testbench for key_event_gen with LONG_CYC=20, DCLICK_CYC=8, REPEAT_CYC=5.
// Directed scenarios followed by random key waveforms; every cycle the DUT
// outputs are compared with a timestamp-based reference model.
module tb_key_event_gen;
    import key_pkg::*;

    localparam int L = 20;
    localparam int D = 8;
    localparam int R = 5;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       key_lvl;
    logic       press_p, release_p, short_p, double_p, long_p, repeat_p, held;
    key_state_e state_dbg;

    always #5 clk = ~clk;

    key_event_gen #(.LONG_CYC(L), .DCLICK_CYC(D), .REPEAT_CYC(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_lvl   (key_lvl),
        .press_p   (press_p),
        .release_p (release_p),
        .short_p   (short_p),
        .double_p  (double_p),
        .long_p    (long_p),
        .repeat_p  (repeat_p),
        .held      (held),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc;

    // ---------------- reference model ----------------
    // Phase of the gesture and the cycle at which that phase began; events
    // fire when the elapsed time since the phase start hits a threshold.
    // phase: 0 idle, 1 first press, 2 gap, 3 second press, 4 long hold.
    int   m_phase;
    int   m_start;
    bit   m_prev;
    logic [6:0] exp_q[$];

    // Observed event bookkeeping for directed timing checks.
    int t_press, t_release, t_short, t_double, t_long, t_rep_first, t_rep_last;
    int n_press, n_release, n_short, n_double, n_long, n_repeat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        t_press = -1; t_release = -1; t_short = -1; t_double = -1; t_long = -1;
        t_rep_first = -1; t_rep_last = -1;
        n_press = 0; n_release = 0; n_short = 0; n_double = 0; n_long = 0; n_repeat = 0;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_start = 0;
        m_prev  = 1'b0;
        cyc     = 0;
        exp_q.delete();
    endtask

    // Expected outputs after clock edge n given the level sampled at that edge.
    task automatic model_edge(input bit k, input int n);
        bit e_press, e_rel, e_short, e_dbl, e_long, e_rep, e_held;
        bit went_down, went_up;
        int elapsed;
        went_up   = k && !m_prev;
        went_down = !k && m_prev;
        m_prev    = k;
        elapsed   = n - m_start;
        e_press = 0; e_rel = 0; e_short = 0; e_dbl = 0; e_long = 0; e_rep = 0;
        case (m_phase)
            0: if (went_up) begin e_press = 1; m_phase = 1; m_start = n; end
            1: if (went_down) begin e_rel = 1; m_phase = 2; m_start = n; end
               else if (elapsed == L) begin e_long = 1; m_phase = 4; m_start = n; end
            2: if (went_up) begin e_press = 1; m_phase = 3; m_start = n; end
               else if (elapsed == D) begin e_short = 1; m_phase = 0; end
            3: if (went_down) begin e_rel = 1; e_dbl = 1; m_phase = 0; end
               else if (elapsed == L) begin e_long = 1; m_phase = 4; m_start = n; end
            default: if (went_down) begin e_rel = 1; m_phase = 0; end
`ifdef KEY_REPEAT_EN
               else if (elapsed > 0 && elapsed % R == 0) e_rep = 1;
`endif
        endcase
        e_held = (m_phase == 1) || (m_phase == 3) || (m_phase == 4);
        exp_q.push_back({e_press, e_rel, e_short, e_dbl, e_long, e_rep, e_held});
    endtask

    // ---------------- driver tasks ----------------
    // Apply one key level for one cycle, then check all outputs #1 after the edge.
    task automatic step(input bit k);
        logic [6:0] obs;
        logic [6:0] exp;
        key_lvl = k;
        @(posedge clk);
        cyc++;
        model_edge(k, cyc);
        #1;
        obs = {press_p, release_p, short_p, double_p, long_p, repeat_p, held};
        exp = exp_q.pop_front();
        check("outputs", 32'(obs), 32'(exp));
        if (press_p)   begin n_press++;   t_press   = cyc; end
        if (release_p) begin n_release++; t_release = cyc; end
        if (short_p)   begin n_short++;   t_short   = cyc; end
        if (double_p)  begin n_double++;  t_double  = cyc; end
        if (long_p)    begin n_long++;    t_long    = cyc; end
        if (repeat_p)  begin
            n_repeat++;
            if (t_rep_first < 0) t_rep_first = cyc;
            t_rep_last = cyc;
        end
    endtask

    task automatic steps(input bit k, input int n);
        for (int i = 0; i < n; i++) step(k);
    endtask

    // Synchronous-looking reset wrapper: rst asserted for two edges with the
    // given key level, released at a falling edge.
    task automatic do_reset(input bit k);
        key_lvl = k;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'({press_p, release_p, short_p, double_p, long_p, repeat_p, held}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_counts();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bit lvl;
        rst = 1'b1;
        key_lvl = 1'b0;
        model_reset();
        clear_counts();

        // Single click: high 5, low.
        do_reset(1'b0);
        steps(1'b1, 5);
        steps(1'b0, 12);
        check("click_press_cyc", 32'(t_press), 32'd1);
        check("click_release_cyc", 32'(t_release), 32'd6);
        check("click_short_cyc", 32'(t_short), 32'd14);
        check("click_no_double", 32'(n_double), 32'd0);
        check("click_no_long", 32'(n_long), 32'd0);

        // Double click: high 3, low 4, high 3, low.
        do_reset(1'b0);
        steps(1'b1, 3);
        steps(1'b0, 4);
        steps(1'b1, 3);
        steps(1'b0, 12);
        check("dbl_presses", 32'(n_press), 32'd2);
        check("dbl_releases", 32'(n_release), 32'd2);
        check("dbl_count", 32'(n_double), 32'd1);
        check("dbl_with_release", 32'(t_double), 32'd11);
        check("dbl_no_short", 32'(n_short), 32'd0);

        // Long press: high 40.
        do_reset(1'b0);
        steps(1'b1, 40);
        check("long_delay", 32'(t_long - t_press), 32'd20);
        check("long_held", 32'(held), 32'd1);
        steps(1'b0, 3);
        check("long_count", 32'(n_long), 32'd1);
`ifdef KEY_REPEAT_EN
        check("repeat_count", 32'(n_repeat), 32'd3);
        check("repeat_first", 32'(t_rep_first - t_press), 32'd25);
        check("repeat_last", 32'(t_rep_last - t_press), 32'd35);
`else
        check("repeat_none", 32'(n_repeat), 32'd0);
`endif

        // Boundary: fall exactly when long_p would fire.
        do_reset(1'b0);
        steps(1'b1, L);
        steps(1'b0, 12);
        check("bnd_release_cyc", 32'(t_release), 32'(L + 1));
        check("bnd_no_long", 32'(n_long), 32'd0);
        check("bnd_short_delay", 32'(t_short - t_release), 32'(D));

        // Reset asserted asynchronously while waiting for a second press.
        do_reset(1'b0);
        steps(1'b1, 3);
        steps(1'b0, 3);
        check("mid_in_wait", 32'(state_dbg), 32'(WAIT_2ND));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_outputs", 32'({press_p, release_p, short_p, double_p, long_p, repeat_p, held}), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_counts();
        steps(1'b0, 15);
        check("mid_no_short", 32'(n_short), 32'd0);

        // Key held high across reset release.
        do_reset(1'b1);
        steps(1'b1, 25);
        check("hold_rst_press", 32'(t_press), 32'd1);
        check("hold_rst_long", 32'(t_long), 32'd21);
        steps(1'b0, 12);

        // Random key waveforms, run lengths spanning every threshold.
        do_reset(1'b0);
        lvl = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            lvl = ~lvl;
            steps(lvl, $urandom_range(1, 30));
        end
        steps(1'b0, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish before limit");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Classifies a debounced key level into single-cycle event pulses: press, release, short click, double click, long press, and optional auto-repeat. It sits directly downstream of the key debouncer and consumes its active-high debounced output. Pulses feed the control/UI logic, which acts on events instead of raw levels.

## Interface
- LONG_CYC, default 1000: cycles a press must be held before it counts as a long press (≥2).
- DCLICK_CYC, default 300: maximum cycles after a release in which a second press forms a double click (≥2).
- REPEAT_CYC, default 200: auto-repeat period once long press is reached (≥2). Used only with KEY_REPEAT_EN.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_lvl  in  1  debounced key level from the debouncer, 1 = pressed.
- press_p  out  1  one-cycle pulse on every press.
- release_p  out  1  one-cycle pulse on every release.
- short_p  out  1  one-cycle pulse: single short click confirmed.
- double_p  out  1  one-cycle pulse: double click confirmed.
- long_p  out  1  one-cycle pulse: long-press threshold reached.
- repeat_p  out  1  one-cycle auto-repeat pulse; tied 0 without KEY_REPEAT_EN.
- held  out  1  level, 1 while the FSM is in a pressed state.

## Operation
- key_lvl is registered into key_q (reset 0).
- Edge definitions: rise = key_lvl & ~key_q; fall = ~key_lvl & key_q.
- One counter cnt, width = clog2(max(LONG_CYC, DCLICK_CYC, REPEAT_CYC)) + 1. It is cleared on every state entry and never wraps, because every threshold forces a state exit or a reload.
- FSM states and transitions:
  - IDLE: on rise, assert press_p and go to PRESSED.
  - PRESSED: cnt increments each cycle.
    - On fall, assert release_p and go to WAIT_2ND.
    - Otherwise, when cnt == LONG_CYC-1, assert long_p and go to LONG_HELD.
  - WAIT_2ND: cnt increments each cycle.
    - On rise, assert press_p and go to PRESSED2.
    - Otherwise, when cnt == DCLICK_CYC-1, assert short_p and go to IDLE.
  - PRESSED2: cnt increments each cycle.
    - On fall, assert release_p and double_p, then go to IDLE.
    - When cnt == LONG_CYC-1, assert long_p only (no short_p or double_p) and go to LONG_HELD.
  - LONG_HELD: on fall, assert release_p and go to IDLE. Repeat behaviour is defined under Configuration.
- Priority: an edge always beats a threshold in the same cycle. Example: a fall on the cycle cnt == LONG_CYC-1 produces release_p, not long_p.
- held = 1 in PRESSED, PRESSED2 and LONG_HELD.
- All outputs are registered. Each pulse is exactly one cycle wide; at most press_p or release_p (plus double_p) is asserted together.

## Timing
- Reset: state IDLE, cnt 0, key_q 0, and all outputs 0.
- A key held through reset release is seen as a rise and produces press_p in the first cycle after reset.
- Press/release latency: press_p and release_p are high in the cycle after the first clock edge at which the new key_lvl is sampled (1 cycle).
- long_p rises exactly LONG_CYC cycles after press_p rises, provided key_lvl stays 1.
- short_p rises exactly DCLICK_CYC cycles after release_p rises, if there is no re-press.
- double_p is coincident with the second release_p.
- rst asserted mid-operation aborts immediately: no pending short_p or double_p is emitted.

## Configuration
- Macro KEY_REPEAT_EN.
- Defined:
  - In LONG_HELD, cnt counts from 0.
  - repeat_p pulses when cnt == REPEAT_CYC-1, and cnt reloads to 0 on the same cycle.
  - First repeat_p is REPEAT_CYC cycles after long_p; later pulses follow every REPEAT_CYC cycles until the fall.
  - A fall on a repeat cycle gives release_p only.
- Undefined: repeat_p is constant 0, REPEAT_CYC is ignored, and cnt is idle in LONG_HELD.

## Structure
- Shared package key_pkg:
  - state enum typedef: IDLE, PRESSED, WAIT_2ND, PRESSED2, LONG_HELD.
  - default constants for LONG_CYC, DCLICK_CYC and REPEAT_CYC.
- One sub-module, key_edge_det: key_q register plus the rise/fall outputs. It is reusable for other keys.
- The FSM, counter and output registers live in key_event_gen.

## Test plan
Bench parameters: LONG_CYC=20, DCLICK_CYC=8, REPEAT_CYC=5.
- Single click, key high 5 cycles then low:
  - press_p at cycle 1, release_p at cycle 6.
  - short_p at cycle 14.
  - No double_p, no long_p.
- Double click, key high 3, low 4, high 3, then low:
  - Two press_p and two release_p.
  - double_p coincident with the second release_p.
  - No short_p.
- Long press, key high 40 cycles:
  - long_p 20 cycles after press_p.
  - held stays 1 throughout.
  - With KEY_REPEAT_EN: repeat_p at +25, +30 and +35 from press_p. Without it: no repeat_p.
- Boundary, key falls on the exact cycle long_p would fire:
  - release_p only, no long_p.
  - Followed by short_p 8 cycles later.
- Reset mid-operation, rst pulsed during WAIT_2ND:
  - All outputs 0.
  - No short_p afterwards.
  - State IDLE.
- Key held high across reset release:
  - press_p in the first cycle after reset.
  - long_p 20 cycles after that.
